// File: rtl/dmem_bridge_if.sv
// Bus bundles for the data-memory bridge: CPU-side request/response and
// SRAM-controller-side command/strobe channels.
interface dmem_req_if;
    logic        req_valid_i;
    logic        req_rw_i;
    logic [31:0] req_addr_i;
    logic [3:0]  req_wbe_n_i;
    logic [31:0] req_wdata_i;
    logic        req_ready_o;
    logic        resp_valid_o;
    logic [31:0] resp_rdata_o;
    logic        resp_err_o;

    modport master (
        output req_valid_i, req_rw_i, req_addr_i, req_wbe_n_i, req_wdata_i,
        input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
    );
    modport slave (
        input  req_valid_i, req_rw_i, req_addr_i, req_wbe_n_i, req_wdata_i,
        output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
    );
endinterface

interface dmem_ctl_if;
    logic        ctl_start_o;
    logic        ctl_rw_o;
    logic [23:0] ctl_addr_o;
    logic [31:0] ctl_data_o;
    logic [3:0]  ctl_data_be_o;
    logic [31:0] ctl_data_i;
    logic        ctl_r_ready_i;
    logic        ctl_w_finish_i;
    logic        ctl_busy_i;

    modport master (
        output ctl_start_o, ctl_rw_o, ctl_addr_o, ctl_data_o, ctl_data_be_o,
        input  ctl_data_i, ctl_r_ready_i, ctl_w_finish_i, ctl_busy_i
    );
    modport slave (
        input  ctl_start_o, ctl_rw_o, ctl_addr_o, ctl_data_o, ctl_data_be_o,
        output ctl_data_i, ctl_r_ready_i, ctl_w_finish_i, ctl_busy_i
    );
endinterface

// File: rtl/dmem_bridge.sv
// MEM-stage to SRAM-controller bridge: one outstanding access, single-cycle
// completion pulse, bounded wait with error completion on timeout.
module dmem_bridge #(
    parameter int TIMEOUT = 255
) (
    input  logic       clk_i,
    input  logic       rst_i,
    dmem_req_if.slave  req,
    dmem_ctl_if.master ctl
);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               accept, cap_rd, ready;
    // Write flag and enables stored active-high so the all-zero reset value
    // presents as "read, no bytes enabled" on the controller side.
    logic               hold_wr_q;
    logic [23:0]        hold_addr_q;
    logic [3:0]         hold_be_q;
    logic [31:0]        hold_wdata_q;
    logic [31:0]        rdata_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        accept  = 1'b0;
        cap_rd  = 1'b0;
        ready   = 1'b0;
        unique case (state_q)
            IDLE: begin
                ready = req.req_valid_i & ~ctl.ctl_busy_i & rst_i;
                if (ready) begin
                    accept = 1'b1;
                    if (req.req_addr_i[31:24] != 8'h00) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                    end else if (!req.req_rw_i && req.req_wbe_n_i == 4'hF) begin
                        state_d = RESP;
                        err_d   = 1'b0;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // A matching strobe takes priority over the timeout in the same cycle.
                if (hold_wr_q ? ctl.ctl_w_finish_i : ctl.ctl_r_ready_i) begin
                    state_d = RESP;
                    err_d   = 1'b0;
                    cap_rd  = ~hold_wr_q;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            hold_wr_q    <= 1'b0;
            hold_addr_q  <= '0;
            hold_be_q    <= '0;
            hold_wdata_q <= '0;
            rdata_q      <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            if (accept) begin
                hold_wr_q    <= ~req.req_rw_i;
                hold_addr_q  <= req.req_addr_i[23:0];
                hold_be_q    <= ~req.req_wbe_n_i;
                hold_wdata_q <= req.req_wdata_i;
            end
            if (cap_rd) begin
                rdata_q <= ctl.ctl_data_i;
            end
        end
    end

    assign req.req_ready_o   = ready;
    assign req.resp_valid_o  = (state_q == RESP);
    assign req.resp_err_o    = (state_q == RESP) & err_q;
    assign req.resp_rdata_o  = rdata_q;
    assign ctl.ctl_start_o   = (state_q == ISSUE);
    assign ctl.ctl_rw_o      = ~hold_wr_q;
    assign ctl.ctl_addr_o    = hold_addr_q;
    assign ctl.ctl_data_o    = hold_wdata_q;
    assign ctl.ctl_data_be_o = ~hold_be_q;
endmodule

// File: doc/dmem_bridge.md
DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum WAIT-state cycles before an error completion.
REQ-002 clk_i  in  1  the single clock; all state changes on its rising edge.
REQ-003 rst_i  in  1  reset, synchronous and active-low.
REQ-004 req_valid_i  in  1  request present from the MEM stage.
REQ-005 req_rw_i  in  1  1 = read, 0 = write.
REQ-006 req_addr_i  in  32  byte address.
REQ-007 req_wbe_n_i  in  4  byte enables, active-low.
REQ-008 req_wdata_i  in  32  write data.
REQ-009 req_ready_o  out  1  request accepted this cycle.
REQ-010 resp_valid_o  out  1  one-cycle completion pulse.
REQ-011 resp_rdata_o  out  32  read data; held until the next read completes.
REQ-012 resp_err_o  out  1  completion is an error; valid with resp_valid_o.
REQ-013 ctl_start_o  out  1  start pulse to the SRAM controller.
REQ-014 ctl_rw_o  out  1  controller read(1)/write(0).
REQ-015 ctl_addr_o  out  24  controller address.
REQ-016 ctl_data_o  out  32  controller write data.
REQ-017 ctl_data_be_o  out  4  controller byte enables, active-low.
REQ-018 ctl_data_i  in  32  controller read data.
REQ-019 ctl_r_ready_i  in  1  read data valid.
REQ-020 ctl_w_finish_i  in  1  write done.
REQ-021 ctl_busy_i  in  1  controller working.

Function
REQ-022 FSM states: IDLE, ISSUE, WAIT, RESP; exactly one state active at a time.
REQ-023 IDLE: req_ready_o = req_valid_i & ~ctl_busy_i; it is 0 in all other states.
REQ-024 IDLE acceptance (req_ready_o=1): latch rw, addr[23:0], wbe_n and wdata into holding registers.
- REQ-024a: if the request is an error (addr[31:24]≠0), go to RESP with err=1; do not issue.
- REQ-024b: else if it is a write with wbe_n=4'hF, go to RESP with err=0; do not issue.
- REQ-024c: otherwise go to ISSUE.
REQ-025 ISSUE: ctl_start_o=1 for exactly one cycle, then WAIT; the timeout counter clears to 0.
REQ-026 ctl_rw_o, ctl_addr_o, ctl_data_o and ctl_data_be_o are driven from the holding registers and stay stable from ISSUE through WAIT.
REQ-027 WAIT, read: on ctl_r_ready_i=1, capture ctl_data_i into resp_rdata_o and go to RESP with err=0.
REQ-028 WAIT, write: on ctl_w_finish_i=1, go to RESP with err=0.
REQ-029 WAIT: a strobe that does not match the latched direction is ignored.
REQ-030 WAIT: the counter increments each cycle without a completion strobe.
- REQ-030a: when the counter reaches TIMEOUT, go to RESP with err=1.
- REQ-030b: a completion strobe in that same cycle wins, giving err=0.
REQ-031 RESP: resp_valid_o=1 for one cycle, then IDLE; a new request can be accepted on the following cycle.
REQ-032 Latency: acceptance at cycle N, start at N+1, strobe at cycle K≥N+2, resp_valid_o at K+1.
REQ-033 Error and empty-write completions: resp_valid_o at N+1.
REQ-034 resp_rdata_o is not updated by writes or error completions.
REQ-035 A request held while ctl_busy_i=1 in IDLE is not accepted; acceptance occurs in the first cycle in IDLE with ctl_busy_i=0.

Reset
REQ-036 rst_i=0 at a rising edge: state→IDLE; counter=0; holding registers=0.
REQ-037 Output values while rst_i=0: ctl_start_o=0, ctl_rw_o=1, ctl_addr_o=0, ctl_data_o=0, ctl_data_be_o=4'hF.
REQ-038 Output values while rst_i=0: req_ready_o=0, resp_valid_o=0, resp_err_o=0, resp_rdata_o=0.
REQ-039 Reset asserted mid-transaction abandons it with no response pulse; controller strobes arriving during or after reset are ignored until a new ISSUE.

Verification
REQ-040 Read, addr 0x000010, r_ready 3 cycles after start with data 0xDEADBEEF -> one start pulse, ctl_addr_o=0x000010, resp_valid_o 1 cycle later, rdata=0xDEADBEEF, err=0.
REQ-041 Write, addr 0x000020, wbe_n 4'b1100, wdata 0x12345678, w_finish after 2 cycles -> ctl_data_be_o=4'b1100, ctl_rw_o=0, resp_valid_o, err=0, resp_rdata_o unchanged.
REQ-042 Read of addr 0x01000000 -> no ctl_start_o, resp_valid_o at N+1 with err=1; write with wbe_n=4'hF -> no start, err=0.
REQ-043 Read with no strobe, TIMEOUT=8 -> resp_valid_o err=1 exactly 8 WAIT cycles after start; a strobe in the 8th cycle instead gives err=0.
REQ-044 req_valid_i held with ctl_busy_i=1 for 5 cycles -> req_ready_o=0 throughout, accepted the cycle busy drops; back-to-back requests -> start pulses separated by RESP+IDLE.
REQ-045 rst_i=0 during WAIT, then r_ready pulse -> no resp_valid_o; all outputs at reset values; next read completes normally.
